// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, CPHA modes and default widths for the SPI clock generator
package spi_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 6;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;
  typedef enum logic {
    CPHA_SAMPLE_LEAD = 1'b0,
    CPHA_SHIFT_LEAD  = 1'b1
  } cpha_e;
endpackage

// File: rtl/spi_sclk_gen_if.sv
// spi_sclk_gen_if: control/strobe bundle between the SPI master FSM and the clock generator
interface spi_sclk_gen_if
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             spi_clk_en;
  logic [DIV_W-1:0] div;
  logic             cpol;
  logic             cpha;
  logic [CNT_W-1:0] nbits;
  logic             start;
  logic             spi_clk;
  logic             sample;
  logic             shift;
  logic             busy;
  logic             done;
  modport master (
    output spi_clk_en, div, cpol, cpha, nbits, start,
    input  spi_clk, sample, shift, busy, done
  );
  modport slave (
    input  spi_clk_en, div, cpol, cpha, nbits, start,
    output spi_clk, sample, shift, busy, done
  );
endinterface

// File: rtl/spi_half_period_cnt.sv
// spi_half_period_cnt: wrapping 0..last counter with synchronous clear and terminal-count flag
module spi_half_period_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] last,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = cnt == last;
  // clear on load, otherwise count and wrap at the terminal value
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: bounded-burst SPI serial clock generator with CPOL/CPHA sample/shift strobes
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic           m_clk,
  input logic           rst,
  spi_sclk_gen_if.slave bus
);
  logic [1:0]       state;
  logic [DIV_W-1:0] div_l;
  logic             cpol_l;
  cpha_e            cpha_l;
  logic [CNT_W-1:0] nbits_l;
  logic [CNT_W:0]   tog;
  logic [CNT_W:0]   tog_nxt;
  logic             hp_tc;
  logic             accept;
  logic             run_en;
  logic             last_tog;
  logic             lead;
  logic             spi_clk_r;
  logic             sample_r;
  logic             shift_r;
  logic             busy_r;
  logic             done_r;
  assign bus.spi_clk = spi_clk_r;
  assign bus.sample  = sample_r;
  assign bus.shift   = shift_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  // start qualification and toggle bookkeeping; odd toggles are leading edges
  always_comb begin
    accept   = (state == S_IDLE) && bus.spi_clk_en && bus.start && (bus.nbits != '0);
    run_en   = bus.spi_clk_en && (state != S_IDLE);
    tog_nxt  = tog + 1'b1;
    last_tog = tog_nxt == {nbits_l, 1'b0};
    lead     = tog_nxt[0];
  end
  spi_half_period_cnt #(.W(DIV_W)) u_hp (
    .clk  (m_clk),
    .rst  (rst),
    .en   (run_en),
    .load (accept),
    .last (div_l),
    .tc   (hp_tc)
  );
  // sequencer: IDLE tracks cpol, RUN toggles at each half-period, TAIL holds idle level one half-period
  always_ff @(posedge m_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      div_l     <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= CPHA_SAMPLE_LEAD;
      nbits_l   <= '0;
      tog       <= '0;
      spi_clk_r <= 1'b0;
      sample_r  <= 1'b0;
      shift_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      sample_r <= 1'b0;
      shift_r  <= 1'b0;
      done_r   <= 1'b0;
      if (bus.spi_clk_en) begin
        case (state)
          S_IDLE: begin
            spi_clk_r <= bus.cpol;
            if (accept) begin
              div_l   <= bus.div;
              cpol_l  <= bus.cpol;
              cpha_l  <= cpha_e'(bus.cpha);
              nbits_l <= bus.nbits;
              tog     <= '0;
              busy_r  <= 1'b1;
              state   <= S_RUN;
            end
          end
          S_RUN: if (hp_tc) begin
            spi_clk_r <= ~spi_clk_r;
            tog       <= tog_nxt;
            sample_r  <= (cpha_l == CPHA_SHIFT_LEAD) ? ~lead : lead;
            shift_r   <= (cpha_l == CPHA_SHIFT_LEAD) ? lead : (~lead && !last_tog);
            state     <= last_tog ? S_TAIL : S_RUN;
          end
          S_TAIL: begin
            spi_clk_r <= cpol_l;
            if (hp_tc) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: table-driven transfers plus reset, freeze, abort and ignore sequences
module tb_spi_sclk_gen;
  logic m_clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  always #5 m_clk = ~m_clk;
  spi_sclk_gen_if #(.DIV_W(8), .CNT_W(6)) bus ();
  spi_sclk_gen #(.DIV_W(8), .CNT_W(6)) dut (.m_clk(m_clk), .rst(rst), .bus(bus));
  typedef struct {
    int div;
    int nbits;
    bit cpol;
    bit cpha;
    int done_e;
    int togs;
    int smp;
    int shf;
    int first;
  } vec_t;
  vec_t vecs[5];
  task automatic step();
    @(posedge m_clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic run_xfer(input vec_t v, input int idx);
    int de, tg, sm, sh, bad, fe;
    bit prev, chg, poke;
    de = -1; tg = 0; sm = 0; sh = 0; bad = 0; fe = -1;
    poke = v.done_e > 8;
    bus.div = v.div[7:0]; bus.nbits = v.nbits[5:0];
    bus.cpol = v.cpol; bus.cpha = v.cpha;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk($sformatf("v%0d_busy_after_accept", idx), int'(bus.busy), 1);
    bus.div = ~v.div[7:0]; bus.nbits = 6'h3f; bus.cpol = ~v.cpol; bus.cpha = ~v.cpha;
    prev = bus.spi_clk;
    for (int e = 1; e <= 2000; e++) begin
      if (poke && e == 3) bus.start = 1'b1;
      if (e == 6) bus.start = 1'b0;
      step();
      chg = bus.spi_clk != prev;
      if (chg) begin
        tg++;
        if (fe < 0) fe = e;
      end
      if (bus.sample) begin
        sm++;
        if (!chg || bus.spi_clk != (v.cpol ^ ~v.cpha)) bad++;
      end
      if (bus.shift) begin
        sh++;
        if (!chg || bus.spi_clk != (v.cpol ^ v.cpha)) bad++;
      end
      if (bus.done) begin
        de = e;
        break;
      end
      if (!bus.busy) bad++;
      prev = bus.spi_clk;
    end
    chk($sformatf("v%0d_done_edge", idx), de, v.done_e);
    chk($sformatf("v%0d_toggles", idx), tg, v.togs);
    chk($sformatf("v%0d_samples", idx), sm, v.smp);
    chk($sformatf("v%0d_shifts", idx), sh, v.shf);
    chk($sformatf("v%0d_first_toggle", idx), fe, v.first);
    chk($sformatf("v%0d_bad_strobe_or_busy", idx), bad, 0);
    chk($sformatf("v%0d_busy_at_done", idx), int'(bus.busy), 0);
    chk($sformatf("v%0d_idle_level", idx), int'(bus.spi_clk), int'(v.cpol));
    bus.cpol = v.cpol; bus.cpha = v.cpha;
    step();
    chk($sformatf("v%0d_done_one_cycle", idx), int'(bus.done), 0);
  endtask
  initial begin
    int cnt, dn, de;
    bit prev;
    vecs[0] = '{div: 0, nbits: 1, cpol: 0, cpha: 0, done_e: 3,  togs: 2,  smp: 1, shf: 0, first: 1};
    vecs[1] = '{div: 3, nbits: 8, cpol: 1, cpha: 1, done_e: 68, togs: 16, smp: 8, shf: 8, first: 4};
    vecs[2] = '{div: 1, nbits: 4, cpol: 0, cpha: 1, done_e: 18, togs: 8,  smp: 4, shf: 4, first: 2};
    vecs[3] = '{div: 2, nbits: 3, cpol: 1, cpha: 0, done_e: 21, togs: 6,  smp: 3, shf: 2, first: 3};
    vecs[4] = '{div: 0, nbits: 5, cpol: 0, cpha: 0, done_e: 11, togs: 10, smp: 5, shf: 4, first: 1};
    rst = 1'b1;
    bus.spi_clk_en = 1'b1; bus.start = 1'b1; bus.nbits = 6'd4;
    bus.div = 8'd0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_spi_clk", int'(bus.spi_clk), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_strobes", int'(bus.sample | bus.shift | bus.done), 0);
    end
    rst = 1'b0; bus.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(bus.busy) + int'(bus.spi_clk) + int'(bus.done);
    end
    chk("post_rst_idle", cnt, 0);
    foreach (vecs[i]) run_xfer(vecs[i], i);
    bus.div = 8'd1; bus.nbits = 6'd4; bus.cpol = 1'b0; bus.cpha = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int e = 1; e <= 6; e++) step();
    chk("frz_level_before", int'(bus.spi_clk), 1);
    bus.spi_clk_en = 1'b0;
    cnt = 0;
    prev = bus.spi_clk;
    for (int e = 7; e <= 16; e++) begin
      step();
      cnt += int'(bus.spi_clk != prev) + int'(bus.sample) + int'(bus.shift) + int'(bus.done) + int'(!bus.busy);
    end
    chk("frz_activity", cnt, 0);
    bus.spi_clk_en = 1'b1;
    cnt = 0; de = -1;
    for (int e = 17; e <= 200; e++) begin
      step();
      if (bus.spi_clk != prev) cnt++;
      prev = bus.spi_clk;
      if (bus.done) begin
        de = e;
        break;
      end
    end
    chk("frz_done_edge", de, 28);
    chk("frz_remaining_toggles", cnt, 5);
    bus.div = 8'd0; bus.nbits = 6'd4;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int e = 1; e <= 5; e++) step();
    chk("abort_level_before", int'(bus.spi_clk), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_spi_clk", int'(bus.spi_clk), 0);
    chk("abort_busy", int'(bus.busy), 0);
    dn = int'(bus.done);
    for (int i = 0; i < 15; i++) begin
      step();
      dn += int'(bus.done) + int'(bus.busy);
    end
    chk("abort_no_done", dn, 0);
    run_xfer('{div: 0, nbits: 2, cpol: 0, cpha: 0, done_e: 5, togs: 4, smp: 2, shf: 1, first: 1}, 5);
    bus.nbits = 6'd0; bus.start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      cnt += int'(bus.busy) + int'(bus.done) + int'(bus.sample);
    end
    bus.start = 1'b0;
    chk("nbits0_ignored", cnt, 0);
    run_xfer('{div: 1, nbits: 3, cpol: 1, cpha: 1, done_e: 14, togs: 6, smp: 3, shf: 3, first: 2}, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
